// File: rtl/aci_tape_writer.sv
// rtl/aci_tape_writer.sv - Apple-1 ACI save path: reads a RAM range and emits it as an FSK tape signal
// Optional build macro: ACI_CHECKSUM_EN appends an XOR checksum byte (seed 0xFF) after the data.
module aci_tape_writer #(
   parameter int ONE_HALF      = 3580,
   parameter int ZERO_HALF     = 1790,
   parameter int SYNC_HALF     = 1432,
   parameter int LEADER_CYCLES = 10000
) (
   input  logic        clk7,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] start_addr,
   input  logic [15:0] end_addr,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_data,
   input  logic        mem_valid,
   output logic        tape_out,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [15:0] ONE_N    = 16'(ONE_HALF - 1);
   localparam logic [15:0] ZERO_N   = 16'(ZERO_HALF - 1);
   localparam logic [15:0] SYNC_N   = 16'(SYNC_HALF - 1);
   localparam logic [15:0] LEADER_N = 16'(LEADER_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LEADER, SYNC, BIT_HI, BIT_LO, DONE} state_t;

   state_t      state_q;
   logic [15:0] cnt_q;        // clocks left in the current half, minus one
   logic [15:0] cyc_q;        // leader cycles left, minus one
   logic        phase_q;      // leader/sync: 0 = high half, 1 = low half
   logic [2:0]  bit_idx_q;
   logic [7:0]  shift_q;      // byte on the wire, current bit in [7]
   logic [7:0]  buf_q;        // prefetched next byte
   logic        buf_valid_q;
   logic [16:0] addr_q;       // next address to fetch; 17 bits so FFFF+1 does not wrap
   logic [15:0] end_q;
   logic        mem_rd_q, tape_q, busy_q, done_q, err_q;
   logic [15:0] mem_addr_q;
`ifdef ACI_CHECKSUM_EN
   logic [7:0]  csum_q;
   logic        csum_phase_q;  // checksum byte already loaded
`endif

   logic        half_end_d, more_fetch_d, at_boundary_d;
   logic [15:0] buf_len_d, cur_len_d, nxt_len_d;

   // Decode of counter expiry, fetch progress and the half length for each bit
   always_comb begin
      half_end_d    = (cnt_q == 16'd0);
      more_fetch_d  = (addr_q <= {1'b0, end_q});
      at_boundary_d = half_end_d &&
                      ((state_q == SYNC && phase_q) ||
                       (state_q == BIT_LO && bit_idx_q == 3'd0));
      buf_len_d     = buf_q[7]   ? ONE_N : ZERO_N;
      cur_len_d     = shift_q[7] ? ONE_N : ZERO_N;
      nxt_len_d     = shift_q[6] ? ONE_N : ZERO_N;
   end

   // Save sequencer: read port, byte buffer, leader/sync/bit timing and status pulses
   always_ff @(posedge clk7) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 16'd0;
         cyc_q       <= 16'd0;
         phase_q     <= 1'b0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'd0;
         buf_q       <= 8'd0;
         buf_valid_q <= 1'b0;
         addr_q      <= 17'd0;
         end_q       <= 16'd0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= 16'd0;
         tape_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef ACI_CHECKSUM_EN
         csum_q       <= 8'hFF;
         csum_phase_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (mem_rd_q && mem_valid) begin
            buf_q       <= mem_data;
            buf_valid_q <= 1'b1;
            addr_q      <= addr_q + 17'd1;
            mem_rd_q    <= 1'b0;
         end
         if (state_q != IDLE && abort) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            tape_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            buf_valid_q <= 1'b0;
         end else if (at_boundary_d) begin
            if (buf_valid_q) begin
               shift_q     <= buf_q;
               buf_valid_q <= 1'b0;
               bit_idx_q   <= 3'd7;
               state_q     <= BIT_HI;
               tape_q      <= 1'b1;
               cnt_q       <= buf_len_d;
`ifdef ACI_CHECKSUM_EN
               csum_q      <= csum_q ^ buf_q;
`endif
               if (more_fetch_d) begin
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= addr_q[15:0];
               end
            end else if (state_q == BIT_LO && !more_fetch_d) begin
`ifdef ACI_CHECKSUM_EN
               if (!csum_phase_q) begin
                  shift_q      <= csum_q;
                  csum_phase_q <= 1'b1;
                  bit_idx_q    <= 3'd7;
                  state_q      <= BIT_HI;
                  tape_q       <= 1'b1;
                  cnt_q        <= csum_q[7] ? ONE_N : ZERO_N;
               end else begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  tape_q  <= 1'b0;
               end
`else
               state_q <= DONE;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               tape_q  <= 1'b0;
`endif
            end else begin
               // next byte is due but the buffer is empty: underrun
               state_q  <= IDLE;
               err_q    <= 1'b1;
               busy_q   <= 1'b0;
               tape_q   <= 1'b0;
               mem_rd_q <= 1'b0;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     if (end_addr >= start_addr) begin
                        addr_q      <= {1'b0, start_addr};
                        end_q       <= end_addr;
                        mem_rd_q    <= 1'b1;
                        mem_addr_q  <= start_addr;
                        busy_q      <= 1'b1;
                        tape_q      <= 1'b1;
                        state_q     <= LEADER;
                        phase_q     <= 1'b0;
                        cnt_q       <= ONE_N;
                        cyc_q       <= LEADER_N;
                        buf_valid_q <= 1'b0;
`ifdef ACI_CHECKSUM_EN
                        csum_q       <= 8'hFF;
                        csum_phase_q <= 1'b0;
`endif
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               LEADER: begin
                  if (!half_end_d) begin
                     cnt_q <= cnt_q - 16'd1;
                  end else if (!phase_q) begin
                     phase_q <= 1'b1;
                     tape_q  <= 1'b0;
                     cnt_q   <= ONE_N;
                  end else if (cyc_q == 16'd0) begin
                     state_q <= SYNC;
                     phase_q <= 1'b0;
                     tape_q  <= 1'b1;
                     cnt_q   <= SYNC_N;
                  end else begin
                     cyc_q   <= cyc_q - 16'd1;
                     phase_q <= 1'b0;
                     tape_q  <= 1'b1;
                     cnt_q   <= ONE_N;
                  end
               end
               SYNC: begin
                  if (!half_end_d) begin
                     cnt_q <= cnt_q - 16'd1;
                  end else begin
                     phase_q <= 1'b1;
                     tape_q  <= 1'b0;
                     cnt_q   <= SYNC_N;
                  end
               end
               BIT_HI: begin
                  if (!half_end_d) begin
                     cnt_q <= cnt_q - 16'd1;
                  end else begin
                     state_q <= BIT_LO;
                     tape_q  <= 1'b0;
                     cnt_q   <= cur_len_d;
                  end
               end
               BIT_LO: begin
                  if (!half_end_d) begin
                     cnt_q <= cnt_q - 16'd1;
                  end else begin
                     shift_q   <= {shift_q[6:0], 1'b0};
                     bit_idx_q <= bit_idx_q - 3'd1;
                     state_q   <= BIT_HI;
                     tape_q    <= 1'b1;
                     cnt_q     <= nxt_len_d;
                  end
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign tape_out = tape_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_aci_tape_writer.sv
// tb/tb_aci_tape_writer.sv - directed self-checking bench for aci_tape_writer
module tb_aci_tape_writer;

   localparam int ONE  = 8;
   localparam int ZERO = 4;
   localparam int SYNC = 3;
   localparam int LEAD = 2;
`ifdef ACI_CHECKSUM_EN
   localparam int BUSY_ONE_BYTE = 230;
`else
   localparam int BUSY_ONE_BYTE = 134;
`endif

   logic        clk7 = 1'b0;
   logic        reset, start, abort;
   logic [15:0] start_addr, end_addr;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_valid;
   logic        tape_out, busy, done, err;

   aci_tape_writer #(
      .ONE_HALF(ONE), .ZERO_HALF(ZERO), .SYNC_HALF(SYNC), .LEADER_CYCLES(LEAD)
   ) dut (
      .clk7(clk7), .reset(reset), .start(start), .abort(abort),
      .start_addr(start_addr), .end_addr(end_addr),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
      .tape_out(tape_out), .busy(busy), .done(done), .err(err)
   );

   always #5 clk7 = ~clk7;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // memory responder: mem_valid on the second negedge after mem_rd rises
   logic [7:0]  mem [0:65535];
   int          lat = 0;
   int          lat_target = 1;
   int          reads = 0;
   int          max_reads = 1000;
   bit          mem_hold = 0;
   logic [15:0] read_log [$];

   always @(negedge clk7) begin
      if (!mem_hold) begin
         if (mem_valid) begin
            mem_valid = 1'b0;
         end else if (mem_rd && reads < max_reads) begin
            if (lat >= lat_target) begin
               mem_valid = 1'b1;
               mem_data  = mem[mem_addr];
               read_log.push_back(mem_addr);
               reads++;
               lat = 0;
            end else begin
               lat++;
            end
         end else begin
            lat = 0;
         end
      end
   end

   // expected tape waveform, one entry per busy cycle
   bit exp_q [$];

   task automatic push_half(input bit v, input int n);
      repeat (n) exp_q.push_back(v);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         push_half(1'b1, b[i] ? ONE : ZERO);
         push_half(1'b0, b[i] ? ONE : ZERO);
      end
   endtask

   task automatic push_preamble();
      exp_q.delete();
      repeat (LEAD) begin
         push_half(1'b1, ONE);
         push_half(1'b0, ONE);
      end
      push_half(1'b1, SYNC);
      push_half(1'b0, SYNC);
   endtask

   int   n_busy, n_done, n_err, mism;
   logic term_tape, term_mem_rd, first_rd;
   logic [15:0] first_addr;

   task automatic run_save(input logic [15:0] sa, input logic [15:0] ea);
      bit fin;
      reads = 0;
      read_log.delete();
      n_busy = 0; n_done = 0; n_err = 0; mism = 0; fin = 0;
      @(negedge clk7);
      start_addr = sa;
      end_addr   = ea;
      start      = 1'b1;
      for (int c = 0; c < 2000 && !fin; c++) begin
         @(negedge clk7);
         start = 1'b0;
         if (c == 0) begin
            first_rd   = mem_rd;
            first_addr = mem_addr;
         end
         if (done) n_done++;
         if (err)  n_err++;
         if (busy) begin
            if (n_busy >= exp_q.size() || tape_out !== exp_q[n_busy]) mism++;
            n_busy++;
         end else begin
            fin         = 1;
            term_tape   = tape_out;
            term_mem_rd = mem_rd;
         end
      end
      if (!fin) check("save_timeout", 32'd0, 32'd1);
      @(negedge clk7);
      if (done) n_done++;
      if (err)  n_err++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      start_addr = 16'h0; end_addr = 16'h0;
      mem_valid = 1'b0; mem_data = 8'h00;
      mem[16'h0280] = 8'hA5;
      mem[16'hFFFE] = 8'h3C;
      mem[16'hFFFF] = 8'h81;
      mem[16'h0000] = 8'hEE;
      mem[16'h0400] = 8'hF0;
      mem[16'h0401] = 8'h11;
      mem[16'h0500] = 8'h22;
      repeat (3) @(negedge clk7);
      reset = 1'b0;
      @(negedge clk7);
      check("rst_tape", tape_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_addr", mem_addr, 16'h0000);

      // single byte 0xA5
      push_preamble();
      push_byte(8'hA5);
`ifdef ACI_CHECKSUM_EN
      push_byte(8'h5A);
`endif
      run_save(16'h0280, 16'h0280);
      check("one_first_rd", first_rd, 1);
      check("one_first_addr", first_addr, 16'h0280);
      check("one_wave", mism, 0);
      check("one_busy_len", n_busy, BUSY_ONE_BYTE);
      check("one_done", n_done, 1);
      check("one_err", n_err, 0);
      check("one_end_tape", term_tape, 0);
      check("one_reads", reads, 1);
      check("one_read_addr", read_log.size() > 0 ? read_log[0] : 16'hDEAD, 16'h0280);

      // rejected start
      exp_q.delete();
      run_save(16'h0300, 16'h02FF);
      check("rej_err", n_err, 1);
      check("rej_busy", n_busy, 0);
      check("rej_tape", term_tape, 0);
      check("rej_mem_rd", term_mem_rd, 0);
      check("rej_done", n_done, 0);
      check("rej_reads", reads, 0);

      // top of memory, two bytes
      push_preamble();
      push_byte(8'h3C);
      push_byte(8'h81);
`ifdef ACI_CHECKSUM_EN
      push_byte(8'h42);
`endif
      run_save(16'hFFFE, 16'hFFFF);
      check("top_wave", mism, 0);
      check("top_busy_len", n_busy, exp_q.size());
      check("top_done", n_done, 1);
      check("top_err", n_err, 0);
      check("top_reads", reads, 2);
      check("top_addr0", read_log.size() > 0 ? read_log[0] : 16'hDEAD, 16'hFFFE);
      check("top_addr1", read_log.size() > 1 ? read_log[1] : 16'hDEAD, 16'hFFFF);

      // underrun: second read never answered
      max_reads = 1;
      push_preamble();
      push_byte(8'hF0);
      run_save(16'h0400, 16'h0401);
      check("und_wave", mism, 0);
      check("und_busy_len", n_busy, 134);
      check("und_err", n_err, 1);
      check("und_done", n_done, 0);
      check("und_tape", term_tape, 0);
      check("und_mem_rd", term_mem_rd, 0);
      max_reads = 1000;

      // abort during leader with a read outstanding
      lat_target = 20;
      reads = 0;
      @(negedge clk7);
      start_addr = 16'h0500; end_addr = 16'h0500; start = 1'b1;
      @(negedge clk7);
      start = 1'b0;
      check("abt_busy_before", busy, 1);
      repeat (4) @(negedge clk7);
      check("abt_rd_outstanding", mem_rd, 1);
      abort = 1'b1;
      @(negedge clk7);
      abort = 1'b0;
      check("abt_busy", busy, 0);
      check("abt_mem_rd", mem_rd, 0);
      check("abt_tape", tape_out, 0);
      check("abt_err", err, 0);
      check("abt_done", done, 0);
      mem_hold  = 1;
      mem_valid = 1'b1;
      mem_data  = 8'h77;
      @(negedge clk7);
      mem_valid = 1'b0;
      repeat (3) @(negedge clk7);
      check("late_busy", busy, 0);
      check("late_mem_rd", mem_rd, 0);
      check("late_tape", tape_out, 0);
      check("late_err", err, 0);
      lat = 0;
      lat_target = 1;
      mem_hold = 0;

      push_preamble();
      push_byte(8'hA5);
`ifdef ACI_CHECKSUM_EN
      push_byte(8'h5A);
`endif
      run_save(16'h0280, 16'h0280);
      check("post_wave", mism, 0);
      check("post_busy_len", n_busy, BUSY_ONE_BYTE);
      check("post_done", n_done, 1);
      check("post_reads", reads, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
